// File: rtl/mem_d1_responder.sv
// mem_d1_responder: memory-side responder for the single-port d1 interface.
// Adds a programmable write-completion delay and a host load/dump port.
module mem_d1_responder #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 16,
  parameter int IDX_SIZE   = 4,
  parameter int WR_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done,
  output logic                busy,
  input  logic [IDX_SIZE-1:0] host_addr,
  input  logic [WIDTH-1:0]    host_wdata,
  input  logic                host_we,
  output logic [WIDTH-1:0]    host_rdata,
  output logic                oob_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // One extra bit so SIZE == 2**IDX_SIZE is representable.
  localparam logic [IDX_SIZE:0] LP_SIZE = (IDX_SIZE+1)'(SIZE);
  localparam logic [3:0]        LP_CNT0 = 4'(WR_LATENCY - 1);
  localparam bit                LP_FAST = (WR_LATENCY <= 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [IDX_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_data;
  logic                r_done;
  logic                r_busy;
  logic                r_oob;
  logic [WIDTH-1:0]    r_hrdata;
  logic [WIDTH-1:0]    r_mem [SIZE];

  logic                w_kin;
  logic                w_hin;
  logic                w_cin;
  logic                w_accept;
  logic                w_commit;
  logic [IDX_SIZE-1:0] w_caddr;
  logic [WIDTH-1:0]    w_cdata;

  assign w_kin = ({1'b0, addr0} < LP_SIZE);
  assign w_hin = ({1'b0, host_addr} < LP_SIZE);
  assign w_cin = ({1'b0, r_addr} < LP_SIZE);

  // A new kernel write is taken only when no earlier one is in flight.
  assign w_accept = !reset && write_en
                  && (LP_FAST || (r_state == S_IDLE));

  // Fast mode writes straight through; slow mode commits the captured
  // request on the edge where the countdown reaches 1.
  assign w_commit = LP_FAST
                  ? (!reset && write_en && w_kin)
                  : (!reset && (r_state == S_WAIT)
                     && (r_cnt == 4'd1) && w_cin);
  assign w_caddr  = LP_FAST ? addr0 : r_addr;
  assign w_cdata  = LP_FAST ? write_data : r_data;

  assign read_data  = w_kin ? r_mem[addr0] : '0;
  assign done       = r_done;
  assign busy       = r_busy;
  assign host_rdata = r_hrdata;
  assign oob_err    = r_oob;

  // Array update: kernel commit is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (host_we && w_hin) begin
      r_mem[host_addr] <= host_wdata;
    end
    if (w_commit) begin
      r_mem[w_caddr] <= w_cdata;
    end
  end

  // Host dump port: registered read of the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hrdata <= '0;
    end else begin
      r_hrdata <= w_hin ? r_mem[host_addr] : '0;
    end
  end

  // Write-completion FSM with registered done/busy/oob outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_oob   <= 1'b0;
    end else begin
      if (w_accept && !w_kin) begin
        r_oob <= 1'b1;
      end
      if (LP_FAST) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= write_en;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_done <= 1'b0;
            if (write_en) begin
              r_addr  <= addr0;
              r_data  <= write_data;
              r_cnt   <= LP_CNT0;
              r_state <= S_WAIT;
              r_busy  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (r_cnt == 4'd1) begin
              r_cnt   <= 4'd0;
              r_state <= S_RESP;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_RESP: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_d1_responder.sv
// tb_mem_d1_responder: four responders with different latencies/sizes,
// each checked every cycle against a timeline reference model.
module tb_mem_d1_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic [3:0]  addr0 [4];
  logic [31:0] wdata [4];
  logic        we    [4];
  logic [3:0]  haddr [4];
  logic [31:0] hwd   [4];
  logic        hwe   [4];
  logic [31:0] rdata [4];
  logic        done  [4];
  logic        busy  [4];
  logic [31:0] hrd   [4];
  logic        oob   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_d1_responder #(
      .WIDTH     (32),
      .SIZE      (g == 1 ? 8 : 16),
      .IDX_SIZE  (4),
      .WR_LATENCY(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 2)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .addr0     (addr0[g]),
      .write_data(wdata[g]),
      .write_en  (we[g]),
      .read_data (rdata[g]),
      .done      (done[g]),
      .busy      (busy[g]),
      .host_addr (haddr[g]),
      .host_wdata(hwd[g]),
      .host_we   (hwe[g]),
      .host_rdata(hrd[g]),
      .oob_err   (oob[g])
    );
  end

  function automatic int lat(int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int sz(int g);
    return (g == 1) ? 8 : 16;
  endfunction

  int n_vec = 0;
  int n_bad = 0;
  int n     = 0;

  logic [31:0] m_mem   [4][16];
  bit          m_known [4][16];
  bit          m_has   [4];
  int          m_e0    [4];
  logic [3:0]  m_pa    [4];
  logic [31:0] m_pd    [4];
  bit          m_oob   [4];
  logic [31:0] m_hr    [4];
  bit          m_hrk   [4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a write accepted at edge e0 commits at e0+L-1, done is
  // seen in the cycle after that edge, busy spans cycles e0..e0+L-1.
  task automatic model_edge();
    for (int g = 0; g < 4; g++) begin
      int L;
      int S;
      bit free;
      L = lat(g);
      S = sz(g);
      if (rst[g] || int'(haddr[g]) >= S) begin
        m_hr[g]  = 32'd0;
        m_hrk[g] = 1'b1;
      end else begin
        m_hr[g]  = m_mem[g][haddr[g]];
        m_hrk[g] = m_known[g][haddr[g]];
      end
      if (hwe[g] && int'(haddr[g]) < S) begin
        m_mem[g][haddr[g]]   = hwd[g];
        m_known[g][haddr[g]] = 1'b1;
      end
      if (rst[g]) begin
        m_has[g] = 1'b0;
        m_oob[g] = 1'b0;
      end else begin
        free = !m_has[g] || n >= m_e0[g] + ((L == 1) ? 1 : L + 1);
        if (we[g] && free) begin
          m_has[g] = 1'b1;
          m_e0[g]  = n;
          m_pa[g]  = addr0[g];
          m_pd[g]  = wdata[g];
          if (int'(addr0[g]) >= S) m_oob[g] = 1'b1;
        end
        if (m_has[g] && n == m_e0[g] + L - 1 && int'(m_pa[g]) < S) begin
          m_mem[g][m_pa[g]]   = m_pd[g];
          m_known[g][m_pa[g]] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      int L;
      int S;
      bit e_done;
      bit e_busy;
      L = lat(g);
      S = sz(g);
      e_done = m_has[g] && (n == m_e0[g] + L - 1);
      e_busy = m_has[g] && (L > 1) && (n >= m_e0[g]) && (n <= m_e0[g] + L - 1);
      chk($sformatf("done%0d", g), 32'(done[g]), 32'(e_done));
      chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(e_busy));
      chk($sformatf("oob%0d", g), 32'(oob[g]), 32'(m_oob[g]));
      if (m_hrk[g]) chk($sformatf("hrd%0d", g), hrd[g], m_hr[g]);
      if (int'(addr0[g]) >= S)
        chk($sformatf("rdoob%0d", g), rdata[g], 32'd0);
      else if (m_known[g][addr0[g]])
        chk($sformatf("rd%0d", g), rdata[g], m_mem[g][addr0[g]]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check_all();
  endtask

  logic [31:0] v;
  logic [31:0] old;
  int          iters;
  bit          main_done;
  bit          got;

  initial begin
    for (int g = 0; g < 4; g++) begin
      rst[g] = 1'b1; addr0[g] = '0; wdata[g] = '0; we[g] = 1'b0;
      haddr[g] = '0; hwd[g] = '0; hwe[g] = 1'b0;
      m_has[g] = 1'b0; m_oob[g] = 1'b0; m_hrk[g] = 1'b0; m_e0[g] = 0;
      for (int a = 0; a < 16; a++) begin
        m_known[g][a] = 1'b0;
        m_mem[g][a]   = '0;
      end
    end
    tick();
    tick();
    for (int g = 0; g < 4; g++) rst[g] = 1'b0;
    chk("rst_busy2", 32'(busy[2]), 32'd0);
    chk("rst_hrd1", hrd[1], 32'd0);

    for (int a = 0; a < 16; a++) begin
      for (int g = 0; g < 4; g++) begin
        haddr[g] = 4'(a); hwd[g] = $urandom; hwe[g] = 1'b1;
      end
      tick();
    end
    for (int g = 0; g < 4; g++) hwe[g] = 1'b0;
    tick();

    // Latency 1: write-through, done next cycle
    addr0[0] = 4'd0; wdata[0] = 32'd5; we[0] = 1'b1;
    tick();
    we[0] = 1'b0;
    chk("l1_done", 32'(done[0]), 32'd1);
    chk("l1_busy", 32'(busy[0]), 32'd0);
    tick();
    chk("l1_rd", rdata[0], 32'd5);
    chk("l1_done0", 32'(done[0]), 32'd0);

    // Latency 3 with an ignored second request
    addr0[1] = 4'd3; wdata[1] = 32'h2A; we[1] = 1'b1;
    #1;
    old = m_mem[1][3];
    tick();
    wdata[1] = 32'h55;
    chk("l3_c1_busy", 32'(busy[1]), 32'd1);
    chk("l3_c1_rd", rdata[1], old);
    chk("l3_c1_done", 32'(done[1]), 32'd0);
    tick();
    we[1] = 1'b0;
    chk("l3_c2_rd", rdata[1], old);
    chk("l3_c2_done", 32'(done[1]), 32'd0);
    tick();
    chk("l3_c3_busy", 32'(busy[1]), 32'd1);
    chk("l3_c3_rd", rdata[1], 32'h2A);
    chk("l3_c3_done", 32'(done[1]), 32'd1);
    tick();
    chk("l3_c4_done", 32'(done[1]), 32'd0);
    chk("l3_c4_rd", rdata[1], 32'h2A);
    tick();

    // Out-of-range kernel write on the 8-word instance
    addr0[1] = 4'd15; wdata[1] = 32'hDEAD; we[1] = 1'b1;
    tick();
    we[1] = 1'b0;
    chk("oob_set", 32'(oob[1]), 32'd1);
    chk("oob_rd", rdata[1], 32'd0);
    tick();
    tick();
    chk("oob_done", 32'(done[1]), 32'd1);
    tick();
    chk("oob_hold", 32'(oob[1]), 32'd1);
    for (int a = 0; a < 8; a++) begin
      haddr[1] = 4'(a);
      tick();
      chk($sformatf("oob_dump%0d", a), hrd[1], m_mem[1][a]);
    end

    // Latency 4 aborted by reset
    addr0[2] = 4'd1; wdata[2] = 32'h77; we[2] = 1'b1;
    #1;
    old = m_mem[2][1];
    tick();
    we[2] = 1'b0;
    chk("rs_busy", 32'(busy[2]), 32'd1);
    tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    chk("rs_busy0", 32'(busy[2]), 32'd0);
    chk("rs_oob", 32'(oob[2]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rs_nodone", 32'(done[2]), 32'd0);
    end
    chk("rs_mem", rdata[2], old);

    // Host preload, then an increment-while-less-than-8 kernel loop
    haddr[3] = 4'd0; hwd[3] = 32'd0; hwe[3] = 1'b1;
    tick();
    hwe[3] = 1'b0;
    tick();
    chk("h0_rd", hrd[3], 32'd0);
    addr0[3] = 4'd0;
    iters = 0;
    main_done = 1'b0;
    for (int it = 0; it < 20; it++) begin
      #1;
      v = rdata[3];
      if (v >= 32'd8) begin
        main_done = 1'b1;
        break;
      end
      wdata[3] = v + 32'd1; we[3] = 1'b1;
      tick();
      we[3] = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (done[3]) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      if (!got) begin
        chk("main_timeout", 32'd0, 32'd1);
        break;
      end
      iters++;
      tick();
    end
    chk("main_done", 32'(main_done), 32'd1);
    chk("main_iters", 32'(iters), 32'd8);
    haddr[3] = 4'd0;
    tick();
    chk("main_h0", hrd[3], 32'd8);

    // Same-edge collision: kernel commit beats host write
    addr0[3] = 4'd4; wdata[3] = 32'h11; we[3] = 1'b1;
    tick();
    we[3] = 1'b0;
    haddr[3] = 4'd4; hwd[3] = 32'h22; hwe[3] = 1'b1;
    tick();
    hwe[3] = 1'b0;
    chk("col_rd", rdata[3], 32'h11);
    tick();
    chk("col_hrd", hrd[3], 32'h11);
    tick();

    // Random traffic on all instances
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < 4; g++) begin
        rst[g]   = ($urandom_range(0, 63) == 0);
        we[g]    = ($urandom_range(0, 2) == 0);
        addr0[g] = 4'($urandom_range(0, 15));
        wdata[g] = $urandom;
        haddr[g] = 4'($urandom_range(0, 15));
        hwd[g]   = $urandom;
        hwe[g]   = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      rst[g] = 1'b0; we[g] = 1'b0; hwe[g] = 1'b0;
    end
    for (int k = 0; k < 6; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_d1_responder.md
Name: mem_d1_responder

Overview:
- Responder (memory side) of the single-port d1 memory interface used by generated `main` components: `addr0`, `write_data`, `write_en`, `read_data`, `done`.
- Serves the component's memory port with a configurable write-completion latency, so control FSMs can be exercised against slow memories.
- Provides a host-side load/dump port for testbench or loader access.
- Acts as a drop-in for `std_mem_d1` when `WR_LATENCY=1`.

Parameters:
- WIDTH, 32, data word width.
- SIZE, 16, number of words.
- IDX_SIZE, 4, address width; requires 2**IDX_SIZE >= SIZE.
- WR_LATENCY, 1, cycles from write acceptance to the `done` pulse; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- addr0  input  IDX_SIZE  kernel word address.
- write_data  input  WIDTH  kernel write data.
- write_en  input  1  kernel write request.
- read_data  output  WIDTH  combinational mem[addr0]; 0 if addr0 >= SIZE.
- done  output  1  one-cycle write-complete pulse.
- busy  output  1  high while a write is pending (state != IDLE).
- host_addr  input  IDX_SIZE  host word address.
- host_wdata  input  WIDTH  host write data.
- host_we  input  1  host write strobe.
- host_rdata  output  WIDTH  registered mem[host_addr]; 0 if out of range.
- oob_err  output  1  sticky flag: kernel write to addr0 >= SIZE.

Behaviour:
- Reset (synchronous, active-high); clock clk.
  - Reset state: IDLE, done=0, busy=0, oob_err=0, host_rdata=0, latency counter 0, pending write discarded.
  - Memory array is NOT cleared.
  - Reset asserted mid-WAIT: the pending write is never committed and no done pulse is issued.
- States: IDLE, WAIT, RESP.
- WR_LATENCY=1 (std_mem_d1-compatible):
  - Every edge with write_en=1 commits mem[addr0] <= write_data.
  - done=1 the following cycle; otherwise done=0.
  - Back-to-back writes are accepted every cycle; done stays high while write_en is held.
  - State never leaves IDLE; busy=0.
- WR_LATENCY=L>1:
  - IDLE & write_en at edge E0: capture addr0 and write_data, counter <= L-1, go to WAIT.
  - WAIT: counter decrements each edge. When it reaches 1, the captured write commits on that edge (edge E0+L-1) and the state goes to RESP.
  - RESP: done=1 for exactly one cycle (the cycle after E0+L-1), then return to IDLE.
  - write_en is ignored in WAIT and RESP. Data and address changes after acceptance have no effect.
- Out-of-range kernel write (captured addr >= SIZE):
  - No memory update.
  - done still pulses at the normal time.
  - oob_err set on the acceptance edge; it stays set until reset.
- read_data:
  - Always combinational from the current array and addr0.
  - A committed write is visible the cycle after its commit edge.
- Host port:
  - host_we=1 writes mem[host_addr] <= host_wdata at the edge; out-of-range host writes are dropped silently.
  - host_rdata <= mem[host_addr] every edge, reading the pre-write (old) value.
- Same-edge collision (kernel commit and host write to the same address): kernel data wins; the host write is lost.
- Widths: no arithmetic on data. Counter width is 4 bits.

Test Plan:
- WR_LATENCY=1: write_en=1, addr0=0, write_data=5 for one cycle → done=1 next cycle; read_data=5 at addr0=0 thereafter; busy=0 throughout.
- WR_LATENCY=3:
  - Write 0x2A at addr 3 accepted at edge 0 → busy=1 in cycles 1..3.
  - read_data at addr 3 still shows the old value in cycles 1..2 and 0x2A from cycle 3.
  - done=1 only in cycle 3.
  - A second write_en pulse in cycle 1 is ignored.
- Out-of-range write at addr0=15 with SIZE=8 → done pulses; memory unchanged (host dump of words 0..7 identical); oob_err=1 and remains 1; read_data=0 at addr0=15.
- WR_LATENCY=4, reset asserted in cycle 2 after accepting 0x77 at addr 1 → done never pulses, mem[1] keeps its old value, busy=0 the cycle after reset, oob_err=0.
- Host load then kernel loop:
  - Host writes mem[0]=0, reads it back (host_rdata=0 one cycle later).
  - Run a `main` increment-while-less-than-8 loop against the block with WR_LATENCY=2 → main.done asserts; host read of addr 0 returns 8.
- Collision, WR_LATENCY=2: kernel write 0x11 to addr 4 commits on the same edge as host_we with 0x22 to addr 4 → mem[4]=0x11.
